// File: rtl/tconv_stream_loader.sv
// Packetised stream to ifmap/weight BRAM write loader for the transpose-conv scheduler.
// Optional trailing checksum word per packet: define TCONV_LOADER_CHECKSUM_EN.
module tconv_stream_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_last,
  input  logic              sched_weight_pending,
  output logic              bram_we,
  output logic              bram_sel,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  output logic              ifmap_write_done,
  output logic              weight_write_done,
  output logic              busy,
  output logic              err_len,
  output logic              err_kind,
`ifdef TCONV_LOADER_CHECKSUM_EN
  output logic              err_chk,
`endif
  input  logic              err_clr,
  output logic [2:0]        dbg_state
);

  localparam logic [2:0] S_HDR   = 3'd0;
  localparam logic [2:0] S_DATA  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_CHK   = 3'd4;

  localparam logic [1:0] KIND_IF = 2'b01;
  localparam logic [1:0] KIND_WT = 2'b10;

  logic [2:0]        state_q, state_d;
  logic              kind_q, kind_d;       // 0 = ifmap, 1 = weight
  logic [ADDR_W-1:0] cnt_q, cnt_d;         // N-1 of the current packet
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic              sel_q, sel_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ifd_q, ifd_d;
  logic              wtd_q, wtd_d;
  logic              err_len_q, err_kind_q;
  logic              set_len, set_kind;
  logic [1:0]        hdr_kind;
  logic              xfer;
`ifdef TCONV_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              err_chk_q, set_chk;
`endif

  assign hdr_kind = s_data[DATA_W-1 -: 2];

  // Handshake: a word moves when s_valid && s_ready on a rising clk edge;
  // s_ready depends on s_valid/s_data only in HDR (weight hold-off).
  always_comb begin
    s_ready = 1'b0;
    case (state_q)
      S_HDR:                  s_ready = !(s_valid && (hdr_kind == KIND_WT) && sched_weight_pending);
      S_DATA, S_DRAIN, S_CHK: s_ready = 1'b1;
      default:                s_ready = 1'b0;
    endcase
    if (rst) s_ready = 1'b0;
  end

  assign xfer = s_valid && s_ready;

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    we_d     = 1'b0;
    sel_d    = sel_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    ifd_d    = ifd_q;
    wtd_d    = wtd_q;
    set_len  = 1'b0;
    set_kind = 1'b0;
`ifdef TCONV_LOADER_CHECKSUM_EN
    sum_d    = sum_q;
    set_chk  = 1'b0;
`endif
    case (state_q)
      S_HDR: if (xfer) begin
        if (hdr_kind == KIND_IF || hdr_kind == KIND_WT) begin
          if (s_last) begin
            set_len = 1'b1;
          end else begin
            kind_d  = (hdr_kind == KIND_WT);
            cnt_d   = s_data[ADDR_W-1:0];
            addr_d  = '0;
            state_d = S_DATA;
            if (hdr_kind == KIND_WT) wtd_d = 1'b0;
            else                     ifd_d = 1'b0;
`ifdef TCONV_LOADER_CHECKSUM_EN
            sum_d   = '0;
`endif
          end
        end else begin
          set_kind = 1'b1;
          if (!s_last) state_d = S_DRAIN;
        end
      end
      S_DATA: if (xfer) begin
        we_d    = 1'b1;
        waddr_d = addr_q;
        wdata_d = s_data;
        sel_d   = kind_q;
        addr_d  = addr_q + 1'b1;
`ifdef TCONV_LOADER_CHECKSUM_EN
        sum_d   = sum_q + s_data;
        if (addr_q == cnt_q) begin
          if (s_last) begin set_len = 1'b1; state_d = S_HDR; end
          else        state_d = S_CHK;
        end else if (s_last) begin
          set_len = 1'b1;
          state_d = S_HDR;
        end
`else
        if (addr_q == cnt_q) begin
          if (s_last) state_d = S_DONE;
          else begin set_len = 1'b1; state_d = S_DRAIN; end
        end else if (s_last) begin
          set_len = 1'b1;
          state_d = S_HDR;
        end
`endif
      end
      S_DRAIN: if (xfer && s_last) state_d = S_HDR;
`ifdef TCONV_LOADER_CHECKSUM_EN
      S_CHK: if (xfer) begin
        // A checksum word without s_last means the packet is longer than declared.
        if (!s_last)             begin set_len = 1'b1; state_d = S_DRAIN; end
        else if (s_data == sum_q) state_d = S_DONE;
        else                      begin set_chk = 1'b1; state_d = S_HDR; end
      end
`endif
      S_DONE: begin
        if (kind_q) wtd_d = 1'b1;
        else        ifd_d = 1'b1;
        state_d = S_HDR;
      end
      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_HDR;
      kind_q     <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      sel_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      ifd_q      <= 1'b0;
      wtd_q      <= 1'b0;
      err_len_q  <= 1'b0;
      err_kind_q <= 1'b0;
`ifdef TCONV_LOADER_CHECKSUM_EN
      sum_q      <= '0;
      err_chk_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      ifd_q      <= ifd_d;
      wtd_q      <= wtd_d;
      // A new error in the same cycle as err_clr survives the clear.
      err_len_q  <= (err_len_q  & ~err_clr) | set_len;
      err_kind_q <= (err_kind_q & ~err_clr) | set_kind;
`ifdef TCONV_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
      err_chk_q  <= (err_chk_q  & ~err_clr) | set_chk;
`endif
    end
  end

  assign bram_we           = we_q;
  assign bram_sel          = sel_q;
  assign bram_addr         = waddr_q;
  assign bram_wdata        = wdata_q;
  assign ifmap_write_done  = ifd_q;
  assign weight_write_done = wtd_q;
  assign busy              = (state_q != S_HDR);
  assign err_len           = err_len_q;
  assign err_kind          = err_kind_q;
`ifdef TCONV_LOADER_CHECKSUM_EN
  assign err_chk           = err_chk_q;
`endif
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_tconv_stream_loader.sv
// Directed bench for tconv_stream_loader: BRAM-write scoreboard plus per-scenario checks.
module tb_tconv_stream_loader;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;
  localparam int SB_W   = 1 + ADDR_W + DATA_W;
  localparam logic [2:0] S_HDR   = 3'd0;
  localparam logic [2:0] S_DRAIN = 3'd2;

  logic              clk, rst;
  logic [DATA_W-1:0] s_data;
  logic              s_valid, s_ready, s_last, sched_weight_pending;
  logic              bram_we, bram_sel;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata;
  logic              ifmap_write_done, weight_write_done, busy, err_len, err_kind, err_clr;
  logic [2:0]        dbg_state;
`ifdef TCONV_LOADER_CHECKSUM_EN
  logic              err_chk;
`endif

  tconv_stream_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .s_last(s_last), .sched_weight_pending(sched_weight_pending),
    .bram_we(bram_we), .bram_sel(bram_sel), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .ifmap_write_done(ifmap_write_done), .weight_write_done(weight_write_done),
    .busy(busy), .err_len(err_len), .err_kind(err_kind),
`ifdef TCONV_LOADER_CHECKSUM_EN
    .err_chk(err_chk),
`endif
    .err_clr(err_clr), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, last_we_cyc = -10, n_writes = 0, if_rises = 0, wt_rises = 0;
  logic prev_if = 1'b0, prev_wt = 1'b0;
  logic [SB_W-1:0] exp_q[$];
  logic [SB_W-1:0] exp_w;

  // Scoreboard: every BRAM write must match the head of exp_q; done edges must trail the last write by one cycle.
  always @(negedge clk) begin
    cyc++;
    if (bram_we === 1'b1) begin
      n_writes++;
      last_we_cyc = cyc;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL write_unexpected: got sel=%0d addr=%0d data=%h, required no write", bram_sel, bram_addr, bram_wdata);
      end else begin
        exp_w = exp_q.pop_front();
        if ({bram_sel, bram_addr, bram_wdata} !== exp_w) begin
          n_fail++;
          $display("FAIL write_data: got %h, required %h", {bram_sel, bram_addr, bram_wdata}, exp_w);
        end
      end
    end
    if (ifmap_write_done === 1'b1 && prev_if !== 1'b1) begin
      if_rises++;
      n_checks++;
      if (cyc !== last_we_cyc + 1) begin
        n_fail++;
        $display("FAIL ifmap_done_timing: rose at cycle %0d, required %0d", cyc, last_we_cyc + 1);
      end
    end
    if (weight_write_done === 1'b1 && prev_wt !== 1'b1) begin
      wt_rises++;
      n_checks++;
      if (cyc !== last_we_cyc + 1) begin
        n_fail++;
        $display("FAIL weight_done_timing: rose at cycle %0d, required %0d", cyc, last_we_cyc + 1);
      end
    end
    prev_if = ifmap_write_done;
    prev_wt = weight_write_done;
  end

  // Driver tasks (all start and end at posedge+1)
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic expect_wr(input logic sel, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_q.push_back({sel, a, d});
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d, input logic l, output int waits);
    s_data = d; s_valid = 1'b1; s_last = l; waits = 0;
    #1;
    while (!s_ready && waits < 40) begin @(posedge clk); #1; waits++; end
    if (!s_ready) begin
      n_checks++; n_fail++;
      $display("FAIL handshake_timeout: s_ready=%0d after %0d cycles, required 1", s_ready, waits);
      s_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b1; s_data = 16'h4003; s_last = 1'b0;
    sched_weight_pending = 1'b0; err_clr = 1'b0;
    #1;
    chk("reset_s_ready_pre", {31'd0, s_ready}, 32'd0);
    step(1);
    chk("reset_s_ready", {31'd0, s_ready}, 32'd0);
    rst = 1'b0; s_valid = 1'b0;
    chk("reset_outputs", {bram_we, bram_sel, bram_addr, bram_wdata, ifmap_write_done},
        32'd0);
    chk("reset_flags", {weight_write_done, busy, err_len, err_kind, dbg_state}, 32'd0);
  endtask

  task automatic test_ifmap();
    int w, wsum;
    wsum = 0;
    for (int i = 0; i < 4; i++) expect_wr(1'b0, ADDR_W'(i), DATA_W'(i + 1));
    send_word(16'h4003, 1'b0, w);
    for (int i = 1; i <= 4; i++) begin send_word(DATA_W'(i), (i == 4), w); wsum += w; end
    chk("ifmap_no_bubbles", wsum, 0);
    chk("ifmap_done_not_yet", {31'd0, ifmap_write_done}, 32'd0);
    step(1);
    chk("ifmap_done", {31'd0, ifmap_write_done}, 32'd1);
    chk("ifmap_weight_untouched", {31'd0, weight_write_done}, 32'd0);
    step(1);
    chk("ifmap_all_written", exp_q.size(), 0);
    chk("ifmap_rises", if_rises, 1);
  endtask

  task automatic test_weight_hold();
    int w, w0;
    w0 = n_writes;
    sched_weight_pending = 1'b1; s_data = 16'h8001; s_valid = 1'b1; s_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_s_ready", {31'd0, s_ready}, 32'd0);
      step(1);
    end
    chk("hold_no_writes", n_writes, w0);
    chk("hold_state", {29'd0, dbg_state}, {29'd0, S_HDR});
    sched_weight_pending = 1'b0;
    #1;
    chk("hold_release_ready", {31'd0, s_ready}, 32'd1);
    expect_wr(1'b1, 10'd0, 16'h000A);
    expect_wr(1'b1, 10'd1, 16'h000B);
    send_word(16'h8001, 1'b0, w);
    send_word(16'h000A, 1'b0, w);
    send_word(16'h000B, 1'b1, w);
    step(2);
    chk("weight_done", {31'd0, weight_write_done}, 32'd1);
    chk("weight_ifmap_kept", {31'd0, ifmap_write_done}, 32'd1);
    chk("weight_rises", wt_rises, 1);
  endtask

  task automatic test_back_to_back();
    int w;
    expect_wr(1'b0, 10'd0, 16'h0007);
    expect_wr(1'b0, 10'd1, 16'h0008);
    send_word(16'h4001, 1'b0, w);
    chk("b2b_ifmap_cleared", {31'd0, ifmap_write_done}, 32'd0);
    send_word(16'h0007, 1'b0, w);
    send_word(16'h0008, 1'b1, w);
    expect_wr(1'b1, 10'd0, 16'h0055);
    send_word(16'h8000, 1'b0, w);
    chk("b2b_header_wait", w, 1);
    chk("b2b_weight_cleared", {31'd0, weight_write_done}, 32'd0);
    send_word(16'h0055, 1'b1, w);
    step(2);
    chk("b2b_ifmap_rises", if_rises, 2);
    chk("b2b_weight_rises", wt_rises, 2);
    chk("b2b_all_written", exp_q.size(), 0);
  endtask

  task automatic test_len_err();
    int w, w0;
    expect_wr(1'b0, 10'd0, 16'h0001);
    expect_wr(1'b0, 10'd1, 16'h0002);
    send_word(16'h4003, 1'b0, w);
    send_word(16'h0001, 1'b0, w);
    send_word(16'h0002, 1'b1, w);
    step(1);
    chk("len_err_set", {31'd0, err_len}, 32'd1);
    chk("len_state_hdr", {29'd0, dbg_state}, {29'd0, S_HDR});
    step(2);
    chk("len_no_done", {31'd0, ifmap_write_done}, 32'd0);
    expect_wr(1'b0, 10'd0, 16'h0009);
    send_word(16'h4000, 1'b0, w);
    chk("len_next_hdr_wait", w, 0);
    send_word(16'h0009, 1'b1, w);
    step(2);
    chk("len_next_done", {31'd0, ifmap_write_done}, 32'd1);
    err_clr = 1'b1; step(1); err_clr = 1'b0;
    chk("len_err_cleared", {31'd0, err_len}, 32'd0);
    w0 = n_writes;
    err_clr = 1'b1;
    send_word(16'h4000, 1'b1, w);
    err_clr = 1'b0;
    chk("len_set_beats_clr", {31'd0, err_len}, 32'd1);
    step(1);
    chk("len_hdr_last_no_write", n_writes, w0);
    chk("len_hdr_last_done_kept", {31'd0, ifmap_write_done}, 32'd1);
    err_clr = 1'b1; step(1); err_clr = 1'b0;
  endtask

  task automatic test_kind_err();
    int w, w0;
    w0 = n_writes;
    send_word(16'hC000, 1'b0, w);
    chk("kind_drain_state", {29'd0, dbg_state}, {29'd0, S_DRAIN});
    chk("kind_busy", {31'd0, busy}, 32'd1);
    send_word(16'h1234, 1'b0, w);
    send_word(16'h5678, 1'b1, w);
    step(1);
    chk("kind_err_set", {31'd0, err_kind}, 32'd1);
    chk("kind_back_to_hdr", {29'd0, dbg_state}, {29'd0, S_HDR});
    chk("kind_no_writes", n_writes, w0);
    err_clr = 1'b1; step(1); err_clr = 1'b0;
    chk("kind_err_cleared", {31'd0, err_kind}, 32'd0);
  endtask

  task automatic test_reset_mid();
    int w;
    expect_wr(1'b0, 10'd0, 16'h0001);
    expect_wr(1'b0, 10'd1, 16'h0002);
    send_word(16'h4003, 1'b0, w);
    send_word(16'h0001, 1'b0, w);
    send_word(16'h0002, 1'b0, w);
    rst = 1'b1; s_valid = 1'b1; s_data = 16'h0003;
    #1;
    chk("mid_reset_s_ready", {31'd0, s_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; s_valid = 1'b0;
    chk("mid_reset_outputs", {bram_we, bram_sel, bram_addr, bram_wdata, ifmap_write_done}, 32'd0);
    chk("mid_reset_flags", {weight_write_done, busy, err_len, err_kind, dbg_state}, 32'd0);
    step(1);
    chk("mid_reset_sb_empty", exp_q.size(), 0);
  endtask

`ifdef TCONV_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int w;
    expect_wr(1'b0, 10'd0, 16'h0005);
    expect_wr(1'b0, 10'd1, 16'h0006);
    send_word(16'h4001, 1'b0, w);
    send_word(16'h0005, 1'b0, w);
    send_word(16'h0006, 1'b0, w);
    send_word(16'h000B, 1'b1, w);
    step(2);
    chk("chk_match_done", {31'd0, ifmap_write_done}, 32'd1);
    chk("chk_match_no_err", {31'd0, err_chk}, 32'd0);
    expect_wr(1'b0, 10'd0, 16'h0005);
    expect_wr(1'b0, 10'd1, 16'h0006);
    send_word(16'h4001, 1'b0, w);
    send_word(16'h0005, 1'b0, w);
    send_word(16'h0006, 1'b0, w);
    send_word(16'h000C, 1'b1, w);
    step(2);
    chk("chk_mismatch_err", {31'd0, err_chk}, 32'd1);
    chk("chk_mismatch_no_done", {31'd0, ifmap_write_done}, 32'd0);
  endtask
`endif

  initial begin
    test_reset();
    test_ifmap();
    test_weight_hold();
    test_back_to_back();
    test_len_err();
    test_kind_err();
    test_reset_mid();
`ifdef TCONV_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
